serial_adder: RTL
=================

# serial_adder

Parametrised bit-serial adder/subtractor for the arithmetic datapath. It accepts two WIDTH-bit operands on a start strobe and processes one bit per clock, LSB first, through a single full-adder cell with a registered carry. It reports the sum, carry-out, signed overflow and zero flags with a one-cycle done pulse. It is the area-optimised alternative to the ripple-carry adder chain when throughput is not critical.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..64.
- Clk  input  1  clock; all state updates on the rising edge.
- Rst  input  1  asynchronous, active-high reset.
- Start  input  1  request; sampled only while Busy=0.
- Sub  input  1  0 = A+B+Cin; 1 = A−B−Cin (Cin acts as borrow-in); sampled with Start.
- Cin  input  1  carry-in (Sub=0) or borrow-in (Sub=1); sampled with Start.
- A  input  WIDTH  operand A; sampled with Start.
- B  input  WIDTH  operand B; sampled with Start.
- Busy  output  1  high while the operation is in progress.
- Done  output  1  one-cycle pulse when results become valid.
- Sum  output  WIDTH  result, modulo 2^WIDTH.
- Cout  output  1  carry out of the MSB; for Sub, 1 = no borrow.
- Ovf  output  1  two's-complement overflow.
- Zero  output  1  Sum == 0.

## Operation
- States: IDLE, RUN, DONE. Reset enters IDLE.
- **IDLE/DONE, Start=1:**
  - Latch A into the shift register SA.
  - Latch B, or ~B when Sub=1, into SB.
  - Set carry register C = Cin XOR Sub.
  - Clear the bit counter.
  - Go to RUN.
- **IDLE/DONE, Start=0:** DONE goes to IDLE; IDLE stays in IDLE.
- **RUN, every cycle:**
  - Compute s = SA[0]^SB[0]^C and c' = majority(SA[0],SB[0],C).
  - Shift s into the MSB of the result register R; R shifts right.
  - Shift SA and SB right by one.
  - Load C with c'.
  - Increment the counter.
- **RUN, last bit:** on the cycle the counter equals WIDTH−1, also capture:
  - Cout ← c'
  - Ovf ← c' XOR C, where C is the carry into the MSB
  - Zero ← ({s,R[WIDTH-1:1]} == 0)
  
  Then go to DONE.
- **Outputs:**
  - Busy = (state==RUN). Done = (state==DONE).
  - Sum, Cout, Ovf and Zero are registered and hold their last result until the next completion.
  - They do not change during RUN; R is internal, and Sum loads from it on entry to DONE.
- Start while Busy=1 is ignored: no queuing, and operand inputs are don't-care.
- A Start accepted in the DONE cycle begins a new operation back to back. Done is high for that one cycle; Busy rises on the next edge.
- Counter width is $clog2(WIDTH). The counter never wraps within an operation.

## Timing
- **Reset values:** state IDLE, Busy=0, Done=0, Sum=0, Cout=0, Ovf=0, Zero=0, and all internal registers 0.
- **Reset assertion:** asynchronous and immediate. Reset mid-RUN aborts the operation with no Done pulse, and all outputs return to their reset values.
- **After reset release:** the first Start is sampled on the first rising edge with Rst low.
- **Latency:** Start sampled at edge t0.
  - Busy=1 from t0 until edge t0+WIDTH.
  - Done=1 and results valid from t0+WIDTH until t0+WIDTH+1.
- **Throughput:** one operation per WIDTH+1 cycles, sustained with back-to-back Start.
- Inputs need only be valid at the Start edge.

## Test plan
- **Reset:** assert Rst mid-RUN (WIDTH=8, 0x12+0x34, after 3 bits) → Busy, Done and all outputs 0 immediately. Release, then Start 0x12+0x34 → after 8 cycles Done=1, Sum=0x34+0x12=0x46, Cout=0, Ovf=0, Zero=0.
- **Add with signed overflow:** Sub=0, Cin=0, A=0x5A, B=0x3C → Sum=0x96, Cout=0, Ovf=1, Zero=0. Done exactly 8 cycles after the Start edge, one cycle wide.
- **Add wrap and carry-in:** A=0xFF, B=0x00, Cin=1 → Sum=0x00, Cout=1, Ovf=0, Zero=1.
- **Subtract:**
  - A=0x10, B=0x20, Cin=0 → Sum=0xF0, Cout=0, Ovf=0.
  - A=0x80, B=0x01 → Sum=0x7F, Cout=1, Ovf=1.
  - A=0x05, B=0x05, Cin=1 → Sum=0xFF, Cout=0.
- **Handshake:**
  - Pulse Start again while Busy with different operands → ignored, and the original result is unchanged.
  - Start held high through the DONE cycle → second operation begins; Done pulses once per operation, 9 cycles apart.
- **Width sweep:** WIDTH=2 and WIDTH=32, 1000 random A, B, Sub, Cin each, compared against a reference model of the sum and flags. Latency is exactly WIDTH cycles in every case.

Source files
------------

// File: rtl/serial_adder_if.sv
// Operand/result bundle for the bit-serial adder/subtractor.
// The requester drives operands and start; the adder returns status and results.
interface serial_adder_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic             sub;
  logic             cin;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output start, sub, cin, a, b,
    input  busy, done, sum, cout, ovf, zero
  );

  modport slave (
    input  start, sub, cin, a, b,
    output busy, done, sum, cout, ovf, zero
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell, LSB first, WIDTH cycles per operation.
// Results and flags are registered and held until the next completion.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  serial_adder_if.slave bus
);
  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] r;
  logic             c;
  logic [CW-1:0]    cnt;

  logic             s_c;
  logic             cn_c;
  logic [WIDTH-1:0] r_next_c;
  logic             last_c;

  // Full-adder cell on the current LSBs and the running carry
  assign s_c      = sa[0] ^ sb[0] ^ c;
  assign cn_c     = (sa[0] & sb[0]) | (sa[0] & c) | (sb[0] & c);
  assign r_next_c = {s_c, r[WIDTH-1:1]};
  assign last_c   = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      sa       <= '0;
      sb       <= '0;
      r        <= '0;
      c        <= 1'b0;
      cnt      <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.sum  <= '0;
      bus.cout <= 1'b0;
      bus.ovf  <= 1'b0;
      bus.zero <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            // Subtraction is A + ~B + ~borrow, so invert B and the borrow-in here
            sa       <= bus.a;
            sb       <= bus.sub ? ~bus.b : bus.b;
            c        <= bus.cin ^ bus.sub;
            cnt      <= '0;
            state    <= RUN;
            bus.busy <= 1'b1;
          end else begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end
        end

        RUN: begin
          r  <= r_next_c;
          sa <= sa >> 1;
          sb <= sb >> 1;
          c  <= cn_c;
          if (last_c) begin
            // c holds the carry into the MSB on this cycle
            bus.sum  <= r_next_c;
            bus.cout <= cn_c;
            bus.ovf  <= cn_c ^ c;
            bus.zero <= (r_next_c == '0);
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            state    <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
          bus.done <= 1'b0;
        end
      endcase
    end
  end
endmodule
